// File: rtl/musb_mem_arbiter_pkg.sv
// musb_mem_arbiter_pkg: shared types and constants
// for the fetch/data memory bus arbiter.
package musb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE = 2'd0,
        MEM_ARB_IBUS = 2'd1,
        MEM_ARB_DBUS = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } mem_arb_grant_t;

    localparam int unsigned MEM_ARB_TIMEOUT_DEFAULT = 255;
    localparam logic [3:0]  MEM_ARB_SEL_WORD        = 4'hF;

endpackage

// File: rtl/musb_mem_arbiter.sv
// musb_mem_arbiter: round-robin sequencer of one shared
// memory bus between fetch and load/store, with timeout.
module musb_mem_arbiter
    import musb_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_addr,
    input  logic        i_enable,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_error,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_sel,
    input  logic        d_we,
    input  logic        d_enable,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_error,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_sel,
    output logic        m_we,
    output logic        m_enable,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    input  logic        m_error,
    output logic        imem_request_stall,
    output logic        dmem_request_stall
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_arb_state_t state;
    mem_arb_state_t state_nxt;
    mem_arb_grant_t last_grant;
    logic [7:0]     tmo_cnt;

    logic        i_elig;
    logic        d_elig;
    logic        pick_i;
    logic        pick_d;
    logic        rsp_hit;
    logic        tmo_hit;
    logic        bus_done;
    logic        xfer_err;
    logic [31:0] xfer_rdata;

    assign imem_request_stall = i_enable & ~i_ready;
    assign dmem_request_stall = d_enable & ~d_ready;

    // Eligibility, round-robin pick and completion decode
    always_comb begin
        i_elig     = i_enable & ~i_ready;
        d_elig     = d_enable & ~d_ready;
        pick_d     = d_elig & (~i_elig | (last_grant == GNT_I));
        pick_i     = i_elig & ~pick_d;
        rsp_hit    = m_ready | m_error;
        tmo_hit    = tmo_cnt >= TMO_LAST;
        bus_done   = rsp_hit | tmo_hit;
        xfer_err   = m_error | ~rsp_hit;
        xfer_rdata = rsp_hit ? m_rdata : 32'h0;
    end

    // Next-state logic for the bus ownership FSM
    always_comb begin
        state_nxt = state;
        unique case (state)
            MEM_ARB_IDLE: begin
                unique case (1'b1)
                    pick_d:  state_nxt = MEM_ARB_DBUS;
                    pick_i:  state_nxt = MEM_ARB_IBUS;
                    default: state_nxt = MEM_ARB_IDLE;
                endcase
            end
            MEM_ARB_IBUS,
            MEM_ARB_DBUS: begin
                if (bus_done) state_nxt = MEM_ARB_IDLE;
            end
            default: state_nxt = MEM_ARB_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MEM_ARB_IDLE;
        else        state <= state_nxt;
    end

    // Bus request latch, timeout counter and response pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_I;
            tmo_cnt    <= 8'h0;
            m_addr     <= 32'h0;
            m_wdata    <= 32'h0;
            m_sel      <= 4'h0;
            m_we       <= 1'b0;
            m_enable   <= 1'b0;
            i_rdata    <= 32'h0;
            i_ready    <= 1'b0;
            i_error    <= 1'b0;
            d_rdata    <= 32'h0;
            d_ready    <= 1'b0;
            d_error    <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            i_error <= 1'b0;
            d_ready <= 1'b0;
            d_error <= 1'b0;
            if (state == MEM_ARB_IDLE) begin
                if (pick_d) begin
                    m_addr     <= d_addr;
                    m_wdata    <= d_wdata;
                    m_sel      <= d_sel;
                    m_we       <= d_we;
                    m_enable   <= 1'b1;
                    tmo_cnt    <= 8'h0;
                    last_grant <= GNT_D;
                end else if (pick_i) begin
                    m_addr     <= i_addr;
                    m_sel      <= MEM_ARB_SEL_WORD;
                    m_we       <= 1'b0;
                    m_enable   <= 1'b1;
                    tmo_cnt    <= 8'h0;
                    last_grant <= GNT_I;
                end
            end else if (bus_done) begin
                m_enable <= 1'b0;
                if (state == MEM_ARB_IBUS) begin
                    i_rdata <= xfer_rdata;
                    i_ready <= i_enable;
                    i_error <= i_enable & xfer_err;
                end else begin
                    d_rdata <= xfer_rdata;
                    d_ready <= d_enable;
                    d_error <= d_enable & xfer_err;
                end
            end else if (tmo_cnt != 8'hFF) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_musb_mem_arbiter.sv
// tb_musb_mem_arbiter: directed checks of grant order,
// latency, timeout, error completion and async reset.
module tb_musb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_enable = 1'b0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        i_error;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_sel = '0;
    logic        d_we = 1'b0;
    logic        d_enable = 1'b0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_error;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_sel;
    logic        m_we;
    logic        m_enable;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        m_error;
    logic        imem_request_stall;
    logic        dmem_request_stall;

    int          n_chk = 0;
    int          n_bad = 0;

    int          bus_cnt = 0;
    int          wait_n = 0;
    logic        rsp_none = 1'b0;
    logic        rsp_err = 1'b0;
    logic [31:0] rsp_data = '0;

    always #5 clk = ~clk;

    // Bus slave: responds wait_n cycles after m_enable rises
    always @(posedge clk) bus_cnt <= m_enable ? bus_cnt + 1 : 0;

    assign m_rdata = rsp_data;
    assign m_ready = m_enable && !rsp_none && !rsp_err
                     && (bus_cnt == wait_n);
    assign m_error = m_enable && !rsp_none && rsp_err
                     && (bus_cnt == wait_n);

    musb_mem_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_addr            (i_addr),
        .i_enable          (i_enable),
        .i_rdata           (i_rdata),
        .i_ready           (i_ready),
        .i_error           (i_error),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_sel             (d_sel),
        .d_we              (d_we),
        .d_enable          (d_enable),
        .d_rdata           (d_rdata),
        .d_ready           (d_ready),
        .d_error           (d_error),
        .m_addr            (m_addr),
        .m_wdata           (m_wdata),
        .m_sel             (m_sel),
        .m_we              (m_we),
        .m_enable          (m_enable),
        .m_rdata           (m_rdata),
        .m_ready           (m_ready),
        .m_error           (m_error),
        .imem_request_stall(imem_request_stall),
        .dmem_request_stall(dmem_request_stall)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_enable = 1'b0;
        d_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] exp_addr [6];
    int          g_i;
    int          g_d;
    logic        saw_rdy;

    initial begin
        exp_addr[0] = 32'h500;
        exp_addr[1] = 32'h300;
        exp_addr[2] = 32'h500;
        exp_addr[3] = 32'h300;
        exp_addr[4] = 32'h500;
        exp_addr[5] = 32'h300;

        // reset state
        do_reset();
        chk("rst_men", {31'b0, m_enable}, 0);
        chk("rst_mwe", {31'b0, m_we}, 0);
        chk("rst_msel", {28'b0, m_sel}, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_drdy", {31'b0, d_ready}, 0);

        // fetch only, zero-wait bus
        rsp_data = 32'hDEADBEEF;
        i_addr   = 32'h100;
        i_enable = 1'b1;
        #1;
        chk("f_stall0", {31'b0, imem_request_stall}, 1);
        chk("f_men0", {31'b0, m_enable}, 0);
        step();
        chk("f_men1", {31'b0, m_enable}, 1);
        chk("f_addr1", m_addr, 32'h100);
        chk("f_sel1", {28'b0, m_sel}, 32'hF);
        chk("f_we1", {31'b0, m_we}, 0);
        chk("f_stall1", {31'b0, imem_request_stall}, 1);
        step();
        chk("f_rdy2", {31'b0, i_ready}, 1);
        chk("f_rdata2", i_rdata, 32'hDEADBEEF);
        chk("f_err2", {31'b0, i_error}, 0);
        chk("f_stall2", {31'b0, imem_request_stall}, 0);
        chk("f_men2", {31'b0, m_enable}, 0);
        i_enable = 1'b0;
        step();
        chk("f_men3", {31'b0, m_enable}, 0);
        chk("f_rdy3", {31'b0, i_ready}, 0);

        // simultaneous fetch and store after reset
        do_reset();
        rsp_data = 32'h5555AAAA;
        i_addr   = 32'h200;
        i_enable = 1'b1;
        d_addr   = 32'h400;
        d_wdata  = 32'h12345678;
        d_sel    = 4'b0011;
        d_we     = 1'b1;
        d_enable = 1'b1;
        step();
        chk("s_men1", {31'b0, m_enable}, 1);
        chk("s_addr1", m_addr, 32'h400);
        chk("s_wdata1", m_wdata, 32'h12345678);
        chk("s_we1", {31'b0, m_we}, 1);
        chk("s_sel1", {28'b0, m_sel}, 32'h3);
        chk("s_istall1", {31'b0, imem_request_stall}, 1);
        step();
        chk("s_drdy2", {31'b0, d_ready}, 1);
        chk("s_istall2", {31'b0, imem_request_stall}, 1);
        d_enable = 1'b0;
        step();
        chk("s_men3", {31'b0, m_enable}, 1);
        chk("s_addr3", m_addr, 32'h200);
        chk("s_we3", {31'b0, m_we}, 0);
        chk("s_sel3", {28'b0, m_sel}, 32'hF);
        chk("s_istall3", {31'b0, imem_request_stall}, 1);
        step();
        chk("s_irdy4", {31'b0, i_ready}, 1);
        chk("s_irdata4", i_rdata, 32'h5555AAAA);
        i_enable = 1'b0;
        step();

        // continuous contention: D,I,D,I,D,I
        rsp_data = 32'hCAFEF00D;
        i_addr   = 32'h300;
        d_addr   = 32'h500;
        d_we     = 1'b0;
        d_sel    = 4'hF;
        i_enable = 1'b1;
        d_enable = 1'b1;
        g_i = 0;
        g_d = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("c_men", {31'b0, m_enable}, 1);
            chk("c_addr", m_addr, exp_addr[k]);
            if (m_addr == 32'h500) g_d++;
            if (m_addr == 32'h300) g_i++;
            step();
            if (exp_addr[k] == 32'h500)
                chk("c_drdy", {31'b0, d_ready}, 1);
            else
                chk("c_irdy", {31'b0, i_ready}, 1);
        end
        i_enable = 1'b0;
        d_enable = 1'b0;
        chk("c_gd", g_d, 3);
        chk("c_gi", g_i, 3);
        chk("c_drdata", d_rdata, 32'hCAFEF00D);
        step();

        // timeout on a data load
        rsp_none = 1'b1;
        d_addr   = 32'h600;
        d_enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t_men", {31'b0, m_enable}, 1);
            chk("t_drdy", {31'b0, d_ready}, 0);
        end
        step();
        chk("t_men5", {31'b0, m_enable}, 0);
        chk("t_drdy5", {31'b0, d_ready}, 1);
        chk("t_derr5", {31'b0, d_error}, 1);
        chk("t_drdata5", d_rdata, 0);
        d_enable = 1'b0;
        step();
        chk("t_men6", {31'b0, m_enable}, 0);
        chk("t_drdy6", {31'b0, d_ready}, 0);

        // bus error on a fetch at the third bus cycle
        rsp_none = 1'b0;
        rsp_err  = 1'b1;
        wait_n   = 2;
        rsp_data = 32'h11112222;
        i_addr   = 32'h700;
        i_enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("e_men", {31'b0, m_enable}, 1);
            chk("e_irdy", {31'b0, i_ready}, 0);
        end
        step();
        chk("e_irdy4", {31'b0, i_ready}, 1);
        chk("e_ierr4", {31'b0, i_error}, 1);
        chk("e_irdata4", i_rdata, 32'h11112222);
        chk("e_men4", {31'b0, m_enable}, 0);
        step();
        chk("e_men5", {31'b0, m_enable}, 0);
        chk("e_irdy5", {31'b0, i_ready}, 0);
        i_enable = 1'b0;
        rsp_err  = 1'b0;
        wait_n   = 0;
        step();

        // asynchronous reset during a data bus wait
        rsp_none = 1'b1;
        d_addr   = 32'h800;
        d_enable = 1'b1;
        step();
        chk("r_men1", {31'b0, m_enable}, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("r_men_async", {31'b0, m_enable}, 0);
        chk("r_maddr", m_addr, 0);
        chk("r_irdata", i_rdata, 0);
        d_enable = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        saw_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (d_ready || m_enable) saw_rdy = 1'b1;
        end
        chk("r_quiet", {31'b0, saw_rdy}, 0);

        // fresh fetch after reset
        rsp_none = 1'b0;
        rsp_data = 32'h0BADF00D;
        i_addr   = 32'h900;
        i_enable = 1'b1;
        step();
        chk("n_men1", {31'b0, m_enable}, 1);
        chk("n_addr1", m_addr, 32'h900);
        step();
        chk("n_irdy2", {31'b0, i_ready}, 1);
        chk("n_irdata2", i_rdata, 32'h0BADF00D);
        chk("n_ierr2", {31'b0, i_error}, 0);
        i_enable = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
